// File: rtl/n163_audio_conditioner.sv
// ---------------------------------------------------------------------------
// n163_audio_conditioner
//
// Post-processing stage for the Namco 163 wavetable generator. Once per
// channel sweep the generator hands over an 11-bit sum of all active channels.
// This block:
//   * normalises that sum by the active channel count, because the real chip
//     time-multiplexes its channels and so the per-channel loudness falls as
//     more channels are enabled,
//   * smooths the sweep-rate stepping with a first-order IIR low-pass,
//   * lets the level decay to silence while sound is disabled (no pop).
//
// Parameters
//   LPF_SHIFT   IIR coefficient alpha = 2^-LPF_SHIFT (0 bypasses the filter)
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   enable       in   mapper enable; low acts as a synchronous clear
//   sample_stb   in   one-clk pulse: sample_in/active_ch/snd_disable valid
//   sample_in    in   [10:0] summed channel output
//   active_ch    in   [2:0]  active channel count minus one
//   snd_disable  in   sound-disable bit; forces the filter input to zero
//   audio_out    out  [15:0] filtered, normalised unsigned level
//   out_valid    out  one-clk pulse when audio_out updates
//   busy         out  high whenever the FSM is not IDLE
//   dbg_state    out  [1:0] current FSM state (IDLE=0, MUL=1, FILT=2, OUT=3)
//
// Handshake: sample_stb is a fire-and-forget strobe with no ready. A strobe
// seen in IDLE starts processing at once; a strobe seen in any other state is
// parked in a one-deep pending slot (newest overwrites) and is started from
// IDLE on the clock after OUT. out_valid is a single-clock pulse that marks
// the edge on which audio_out took its new value.
//
// Timing: strobe sampled at edge E0 -> 12 MUL edges (E1..E12) -> FILT edge
// (E13, y updated) -> OUT edge (E14, audio_out and out_valid registered).
// ---------------------------------------------------------------------------
module n163_audio_conditioner #(
  parameter int LPF_SHIFT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        sample_stb,
  input  logic [10:0] sample_in,
  input  logic [2:0]  active_ch,
  input  logic        snd_disable,
  output logic [15:0] audio_out,
  output logic        out_valid,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FILT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  // Gain = floor(2048 / N) for N active channels, so that a full-scale sum
  // lands on the same output level regardless of channel count.
  function automatic logic [11:0] gain_of(input logic [2:0] ch);
    logic [11:0] g;
    case (ch)
      3'd0:    g = 12'd2048;
      3'd1:    g = 12'd1024;
      3'd2:    g = 12'd682;
      3'd3:    g = 12'd512;
      3'd4:    g = 12'd409;
      3'd5:    g = 12'd341;
      3'd6:    g = 12'd292;
      default: g = 12'd256;
    endcase
    return g;
  endfunction

  // Datapath registers
  logic [22:0] mcand;      // x, shifted left one place per MUL clock
  logic [11:0] gain;       // held constant for the whole multiply
  logic [22:0] product;
  logic [3:0]  bit_cnt;
  logic [15:0] y;          // filter state

  // Pending slot for a strobe that arrives while busy
  logic        pend_valid;
  logic [10:0] pend_x;
  logic [2:0]  pend_ch;
  logic        pend_dis;

  // Start selection: a live strobe is newer than anything pending.
  logic        start;
  logic [10:0] sel_x;
  logic [2:0]  sel_ch;
  logic        sel_dis;

  always_comb begin
    start   = (state == IDLE) && (sample_stb || pend_valid);
    sel_x   = pend_x;
    sel_ch  = pend_ch;
    sel_dis = pend_dis;
    if (sample_stb) begin
      sel_x   = sample_in;
      sel_ch  = active_ch;
      sel_dis = snd_disable;
    end
  end

  // Filter arithmetic. t saturates to 16 bits; the step is an arithmetic
  // shift, i.e. rounds toward minus infinity, so a decaying y reaches 0.
  logic [15:0]        t_sat;
  logic signed [17:0] diff;
  logic signed [17:0] step;
  logic signed [17:0] y_sum;
  logic [15:0]        y_next;

  always_comb begin
    t_sat  = (|product[22:20]) ? 16'hFFFF : product[19:4];
    diff   = $signed({2'b00, t_sat}) - $signed({2'b00, y});
    step   = diff >>> LPF_SHIFT;
    y_sum  = $signed({2'b00, y}) + step;
    y_next = y_sum[15:0];
    if (y_sum < 18'sd0) begin
      y_next = 16'h0000;
    end else if (y_sum > 18'sd65535) begin
      y_next = 16'hFFFF;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = MUL;
      MUL:  if (bit_cnt == 4'd11) state_nx = FILT;
      FILT: state_nx = OUT;
      OUT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (!enable) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand      <= '0;
      gain       <= '0;
      product    <= '0;
      bit_cnt    <= '0;
      y          <= '0;
      audio_out  <= '0;
      out_valid  <= 1'b0;
      pend_valid <= 1'b0;
      pend_x     <= '0;
      pend_ch    <= '0;
      pend_dis   <= 1'b0;
    end else if (!enable) begin
      mcand      <= '0;
      gain       <= '0;
      product    <= '0;
      bit_cnt    <= '0;
      y          <= '0;
      audio_out  <= '0;
      out_valid  <= 1'b0;
      pend_valid <= 1'b0;
      pend_x     <= '0;
      pend_ch    <= '0;
      pend_dis   <= 1'b0;
    end else begin
      out_valid <= 1'b0;

      // Any strobe outside IDLE is parked; a later one overwrites it.
      if (sample_stb && (state != IDLE)) begin
        pend_valid <= 1'b1;
        pend_x     <= sample_in;
        pend_ch    <= active_ch;
        pend_dis   <= snd_disable;
      end

      case (state)
        IDLE: begin
          if (start) begin
            mcand      <= {12'd0, (sel_dis ? 11'd0 : sel_x)};
            gain       <= gain_of(sel_ch);
            product    <= '0;
            bit_cnt    <= '0;
            pend_valid <= 1'b0;
          end
        end
        MUL: begin
          // LSB-first shift-add, one gain bit per clock.
          if (gain[bit_cnt]) begin
            product <= product + mcand;
          end
          mcand   <= {mcand[21:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
        end
        FILT: begin
          y <= y_next;
        end
        OUT: begin
          audio_out <= y;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
